alu_arbiter: RTL and testbench

Sequences and shares the single combinational ALU between two requesters (Req0, Req1) using round-robin arbitration. It accepts an operation request via a valid/ready handshake and drives exactly one ALU control strobe plus both operands. It captures Alu_Out into a result register and returns the result with a one-cycle Done pulse to the requester that was granted. It sits between the requesters (e.g. the control unit and a DMA/test port) and the ALU.

---
 rtl/alu_req_if.sv | 27 ++
 rtl/alu_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_if.sv
// Requester-side handshake bundle for the ALU arbiter.
// One instance per requester: opcode, operands, valid/ready.
interface alu_req_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  Valid;
  logic [1:0]            Op;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  Ready;

  modport master (
    output Valid,
    output Op,
    output A,
    output B,
    input  Ready
  );

  modport slave (
    input  Valid,
    input  Op,
    input  A,
    input  B,
    output Ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Accept in IDLE, strobe the ALU in ISSUE, pulse Done in CAPTURE.
module alu_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  alu_req_if.slave              Req0,
  alu_req_if.slave              Req1,
  output logic                  Alu_Add,
  output logic                  Alu_Sub,
  output logic                  Alu_Mul,
  output logic                  Alu_Pass,
  output logic [DATA_WIDTH-1:0] Reg1_Out,
  output logic [DATA_WIDTH-1:0] Reg2_Out,
  input  logic [DATA_WIDTH-1:0] Alu_Out,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Done0,
  output logic                  Done1,
  output logic                  Busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] reg1_q, reg1_d;
  logic [DATA_WIDTH-1:0] reg2_q, reg2_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;

  logic idle;
  logic issue;
  logic gnt0;
  logic gnt1;

  assign idle  = (state_q == IDLE);
  assign issue = (state_q == ISSUE);

  // On a tie, serve whoever was not granted last (last_q=1 favours Req0).
  assign gnt1 = idle & Req1.Valid
              & (~Req0.Valid | ~last_q);
  assign gnt0 = idle & Req0.Valid & ~gnt1;

  assign Req0.Ready = gnt0 & ~Reset;
  assign Req1.Ready = gnt1 & ~Reset;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    last_d   = last_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    result_d = result_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          state_d = ISSUE;
          last_d  = gnt1;
          op_d    = gnt1 ? Req1.Op : Req0.Op;
          reg1_d  = gnt1 ? Req1.A  : Req0.A;
          reg2_d  = gnt1 ? Req1.B  : Req0.B;
        end
      end
      ISSUE: begin
        state_d  = CAPTURE;
        result_d = Alu_Out;
        done0_d  = ~last_q;
        done1_d  = last_q;
      end
      CAPTURE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      last_q   <= 1'b1;
      reg1_q   <= '0;
      reg2_q   <= '0;
      result_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      last_q   <= last_d;
      reg1_q   <= reg1_d;
      reg2_q   <= reg2_d;
      result_q <= result_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  always_comb begin
    Alu_Add  = 1'b0;
    Alu_Sub  = 1'b0;
    Alu_Mul  = 1'b0;
    Alu_Pass = 1'b0;
    if (issue) begin
      unique case (op_q)
        OP_ADD:  Alu_Add  = 1'b1;
        OP_SUB:  Alu_Sub  = 1'b1;
        OP_MUL:  Alu_Mul  = 1'b1;
        OP_PASS: Alu_Pass = 1'b1;
        default: Alu_Add  = 1'b0;
      endcase
    end
  end

  assign Reg1_Out = reg1_q;
  assign Reg2_Out = reg2_q;
  assign Result   = result_q;
  assign Done0    = done0_q;
  assign Done1    = done1_q;
  assign Busy     = ~idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, transaction-level model,
// directed scenarios plus randomized traffic on both requesters.
module tb_alu_arbiter;

  localparam int DW = 16;

  logic          Clk;
  logic          Reset;
  logic          Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass;
  logic [DW-1:0] Reg1_Out, Reg2_Out, Alu_Out, Result;
  logic          Done0, Done1, Busy;

  alu_req_if #(.DATA_WIDTH(DW)) r0 ();
  alu_req_if #(.DATA_WIDTH(DW)) r1 ();

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Req0     (r0),
    .Req1     (r1),
    .Alu_Add  (Alu_Add),
    .Alu_Sub  (Alu_Sub),
    .Alu_Mul  (Alu_Mul),
    .Alu_Pass (Alu_Pass),
    .Reg1_Out (Reg1_Out),
    .Reg2_Out (Reg2_Out),
    .Alu_Out  (Alu_Out),
    .Result   (Result),
    .Done0    (Done0),
    .Done1    (Done1),
    .Busy     (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // The external ALU, driven only by the strobes.
  always_comb begin
    Alu_Out = '0;
    if (Alu_Add)  Alu_Out = Reg1_Out + Reg2_Out;
    if (Alu_Sub)  Alu_Out = Reg1_Out - Reg2_Out;
    if (Alu_Mul)  Alu_Out = Reg1_Out * Reg2_Out;
    if (Alu_Pass) Alu_Out = Reg2_Out;
  end

  int errors = 0;
  int checks = 0;

  // Transaction model: phase counts cycles since acceptance (0 = idle).
  bit          mv = 0;
  int          m_phase;
  bit          m_last;
  bit          m_id;
  logic [1:0]  m_op;
  logic [15:0] m_a, m_b, m_res;
  int          nacc = 0;
  int          glog[$];

  function automatic logic [15:0] ref_alu(input logic [1:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    longint x;
    case (op)
      2'd0:    x = longint'(a) + longint'(b);
      2'd1:    x = longint'(a) - longint'(b) + 65536;
      2'd2:    x = longint'(a) * longint'(b);
      default: x = longint'(b);
    endcase
    return 16'(x % 65536);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bit rst);
    bit e0, e1;
    logic [3:0] es, os;
    e0 = 0;
    e1 = 0;
    if (m_phase == 0 && !rst) begin
      if (r0.Valid && r1.Valid) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = r0.Valid;
        e1 = r1.Valid;
      end
    end
    es = (m_phase == 1) ? (4'b1000 >> m_op) : 4'b0000;
    os = {Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass};
    chk("ready0", r0.Ready, e0);
    chk("ready1", r1.Ready, e1);
    chk("both_ready", r0.Ready & r1.Ready, 0);
    chk("onehot", ($countones(os) <= 1), 1);
    chk("strobes", os, es);
    chk("reg1", Reg1_Out, m_a);
    chk("reg2", Reg2_Out, m_b);
    chk("result", Result, m_res);
    chk("done0", Done0, (m_phase == 2 && m_id == 0));
    chk("done1", Done1, (m_phase == 2 && m_id == 1));
    chk("busy", Busy, (m_phase != 0));
    if (r0.Ready) glog.push_back(0);
    if (r1.Ready) glog.push_back(1);
    if (rst) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (e0 || e1) begin
        m_id   = e1;
        m_last = e1;
        m_op   = e1 ? r1.Op : r0.Op;
        m_a    = e1 ? r1.A  : r0.A;
        m_b    = e1 ? r1.B  : r0.B;
        nacc++;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_res   = ref_alu(m_op, m_a, m_b);
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic cyc(input bit rst,
                     input bit v0, input logic [1:0] o0,
                     input logic [15:0] a0, input logic [15:0] b0,
                     input bit v1, input logic [1:0] o1,
                     input logic [15:0] a1, input logic [15:0] b1);
    @(negedge Clk);
    Reset    = rst;
    r0.Valid = v0;
    r0.Op    = o0;
    r0.A     = a0;
    r0.B     = b0;
    r1.Valid = v1;
    r1.Op    = o1;
    r1.A     = a1;
    r1.B     = b1;
    #1;
    if (mv) check_all(rst);
    if (rst) begin
      mv     = 1;
      m_phase = 0;
      m_last = 1;
      m_a    = '0;
      m_b    = '0;
      m_res  = '0;
    end
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_op1(input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp);
    cyc(0, 0, 0, 0, 0, 1, op, a, b);
    chk("op1_ready", r1.Ready, 1);
    idle_cyc();
    chk("op1_strobe", {Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass},
        4'b1000 >> op);
    idle_cyc();
    chk("op1_done1", Done1, 1);
    chk("op1_done0", Done0, 0);
    chk("op1_result", Result, exp);
  endtask

  initial begin
    int start;
    Reset = 1;
    r0.Valid = 0; r0.Op = 0; r0.A = 0; r0.B = 0;
    r1.Valid = 0; r1.Op = 0; r1.A = 0; r1.B = 0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_cyc();
    chk("rst_result", Result, 0);
    chk("rst_busy", Busy, 0);

    // Single add from Req0.
    cyc(0, 1, 0, 7, 5, 0, 0, 0, 0);
    chk("add_ready0", r0.Ready, 1);
    idle_cyc();
    chk("add_strobe", Alu_Add, 1);
    chk("add_reg1", Reg1_Out, 7);
    chk("add_reg2", Reg2_Out, 5);
    idle_cyc();
    chk("add_done0", Done0, 1);
    chk("add_done1", Done1, 0);
    chk("add_result", Result, 12);

    // Decode and wrap from Req1.
    run_op1(1, 3, 5, 16'hFFFE);
    run_op1(2, 300, 300, 16'h5F90);
    run_op1(3, 9, 42, 42);

    // Tie: both held high, grants alternate starting with Req0.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    glog.delete();
    for (int i = 0; i < 12; i++)
      cyc(0, 1, 0, 16'd100, 16'd1, 1, 1, 16'd50, 16'd7);
    chk("rr_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk($sformatf("rr_grant%0d", i), glog[i], i % 2);

    // Randomized traffic for 200 accepted operations.
    start = nacc;
    for (int n = 0; n < 3000 && nacc < start + 200; n++)
      cyc(0, ($urandom_range(3) != 0), 2'($urandom),
          16'($urandom), 16'($urandom),
          ($urandom_range(3) != 0), 2'($urandom),
          16'($urandom), 16'($urandom));
    chk("rand_ops", (nacc - start >= 200), 1);

    // Reset during ISSUE of a mul drops the operation.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 300, 300, 0, 0, 0, 0);
    chk("mr_ready0", r0.Ready, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mr_mul", Alu_Mul, 1);
    idle_cyc();
    chk("mr_strobes", {Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass}, 0);
    chk("mr_result", Result, 0);
    chk("mr_busy", Busy, 0);
    chk("mr_done0", Done0, 0);
    idle_cyc();
    chk("mr_done0b", Done0, 0);
    run_op1(0, 4, 5, 9);

    // Operands latched at acceptance survive input changes.
    cyc(0, 1, 0, 11, 22, 0, 0, 0, 0);
    cyc(0, 0, 0, 99, 99, 0, 0, 0, 0);
    chk("stab_reg1", Reg1_Out, 11);
    chk("stab_reg2", Reg2_Out, 22);
    cyc(0, 0, 0, 77, 66, 0, 0, 0, 0);
    chk("stab_result", Result, 33);
    idle_cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
